// File: rtl/xi_pkg.sv
// xi_pkg: shared defaults and types for the xi_merge lane merger.
//   NUM_XI_DEF  default number of merged lanes
//   DW_DEF      default per-lane data width
//   CNT_W       width of each per-lane accept counter
//   lane_data_t / lane_idx_t  lane payload and lane index at the default sizes
//   wrap_inc()  modular increment used by the round-robin search
package xi_pkg;

  localparam int unsigned NUM_XI_DEF = 2;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned CNT_W      = 16;

  typedef logic [DW_DEF-1:0]             lane_data_t;
  typedef logic [$clog2(NUM_XI_DEF)-1:0] lane_idx_t;

  // (idx + k) mod n for idx < n and k <= n, without a divider.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned k,
                                           input int unsigned n);
    int unsigned s;
    s = idx + k;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/xi_merge_fifo.sv
// xi_merge_fifo: synchronous FIFO holding merged {src, data} words.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears pointers and count)
//   push, wdata       write request and word; ignored when full
//   pop               read request; ignored when empty
//   rdata             head word, forced to zero while empty
//   full, empty       occupancy flags
//   count             number of stored words, 0..DEPTH
module xi_merge_fifo #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Zero head while empty so the output is defined before the first push.
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + AW'(1);  // DEPTH is a power of two: natural wrap
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/xi_merge.sv
// xi_merge: round-robin merge of NUM_XI upstream lanes into one FIFO-buffered stream.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_data    per-lane requests and data
//   in_ready            one-hot grant, combinational from in_valid, rr pointer, FIFO count
//   out_valid/out_data  FIFO head
//   out_src             lane index that produced the head word
//   out_ready           consumer accept
//   grant_cnt           per-lane saturating accept counters
// Build option: define XI_MERGE_STATS_EN to instantiate the grant_cnt counters;
// otherwise grant_cnt is tied to zero and no counter state exists.
module xi_merge
  import xi_pkg::*;
#(
  parameter int unsigned NUM_XI = NUM_XI_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_XI-1:0]              in_valid,
  input  logic [NUM_XI-1:0][DW-1:0]      in_data,
  output logic [NUM_XI-1:0]              in_ready,
  output logic                           out_valid,
  output logic [DW-1:0]                  out_data,
  output logic [$clog2(NUM_XI)-1:0]      out_src,
  input  logic                           out_ready,
  output logic [NUM_XI-1:0][CNT_W-1:0]   grant_cnt
);

  localparam int unsigned SW = $clog2(NUM_XI);
  localparam int unsigned FW = SW + DW;

  logic [SW-1:0]         last_q, last_d;
  logic                  en_q, en_d;
  logic [SW-1:0]         grant_idx;
  logic                  grant_any;
  logic                  can_accept;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;
  logic [$clog2(DEPTH):0] fifo_count;

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_XI; k++) begin
      idx = wrap_inc(32'(last_q), k, NUM_XI);
      if (!grant_any && in_valid[SW'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = SW'(idx);
      end
    end
  end

  // en_q keeps in_ready low for the first cycle after reset is released.
  assign can_accept = rst_n & en_q & ~fifo_full;
  assign push       = grant_any & can_accept;
  assign in_ready   = push ? (NUM_XI'(1) << grant_idx) : '0;
  assign fifo_wdata = {grant_idx, in_data[grant_idx]};

  assign out_valid  = rst_n & ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign {out_src, out_data} = fifo_rdata;

  always_comb begin
    en_d   = 1'b1;
    last_d = push ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= SW'(NUM_XI - 1);  // lane 0 wins the first search
      en_q   <= 1'b0;
    end else begin
      last_q <= last_d;
      en_q   <= en_d;
    end
  end

  xi_merge_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef XI_MERGE_STATS_EN
  logic [NUM_XI-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_XI; i++) begin
      if (in_valid[i] && in_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = '0;
`endif

  // Occupancy is only observed through full/empty here.
  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: doc/xi_merge.md
XI_MERGE -- requirements
Module: xi_merge

Interface
REQ-001 SHALL have parameter NUM_XI, default 2: number of upstream DUT lanes merged (range 2..8).
REQ-002 SHALL have parameter DW, default 8: data width per lane.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries (power of two, at least 2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  NUM_XI  per-lane request from the DUT instances.
REQ-007 in_data  input  NUM_XI x DW  per-lane data.
REQ-008 in_ready  output  NUM_XI  one-hot grant; at most one bit set per cycle.
REQ-009 out_valid  output  1  FIFO head valid.
REQ-010 out_data  output  DW  FIFO head data.
REQ-011 out_src  output  $clog2(NUM_XI)  lane index of the FIFO head.
REQ-012 out_ready  input  1  consumer accepts head.
REQ-013 grant_cnt  output  NUM_XI x 16  per-lane accept counters (see Configuration).

Function
REQ-014 Lane transfer SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge.
REQ-015 Output transfer SHALL occur when out_valid and out_ready are both high at a rising edge.
REQ-016 in_ready SHALL be combinational from in_valid, the rr pointer and FIFO count; never from out_ready.
REQ-017 in_ready SHALL be all-zero when FIFO count equals DEPTH, including cycles with a pop.
REQ-018 Arbitration SHALL be round-robin: search starts at lane (last_grant+1) mod NUM_XI, first valid lane wins.
REQ-019 last_grant SHALL update only on a lane transfer; idle cycles leave it unchanged.
REQ-020 An accepted word SHALL appear at out_* no earlier than the following cycle (1-cycle minimum latency, no bypass).
REQ-021 FIFO order SHALL be strict accept order; out_src SHALL carry the granted lane index with the data.
REQ-022 Simultaneous push and pop with count below DEPTH SHALL leave count unchanged.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits and never exceed DEPTH.
REQ-024 out_valid SHALL equal (count != 0); out_data/out_src SHALL hold when out_valid is high and out_ready is low.
REQ-025 A lane holding in_valid without a grant SHALL wait at most NUM_XI-1 grants to other lanes.

Reset
REQ-026 While rst_n is low at a clock edge: count=0, pointers=0, last_grant=NUM_XI-1 (lane 0 first), grant_cnt=0.
REQ-027 During and one cycle after reset: out_valid=0, in_ready=0.
REQ-028 Reset mid-operation SHALL discard all FIFO contents with no partial output.
REQ-029 out_data and out_src SHALL be 0 after reset until the first push.

Configuration
REQ-030 Macro XI_MERGE_STATS_EN: when defined, grant_cnt[i] SHALL increment on each lane-i transfer, saturate at 16'hFFFF, and clear on reset.
REQ-031 Without XI_MERGE_STATS_EN, grant_cnt SHALL be constant 0 and no counter flops SHALL exist; all other behaviour is identical.

Structure
REQ-032 Package xi_pkg SHALL hold the NUM_XI default, the DW default, and the typedefs for lane data and lane index.
REQ-033 The FIFO SHALL be sub-module xi_merge_fifo (push/pop/full/empty/count); the arbiter and stats SHALL stay in xi_merge.
REQ-034 xi_merge SHALL sit downstream of the dut[i] instances, lane i driven by xi[i], on the same clk.

Verification
REQ-035 Single lane: lane 1 sends 8'hA5 once, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_src=1.
REQ-036 Contention: both lanes hold valid continuously, out_ready=1 -> grants alternate 0,1,0,1; out_src matches.
REQ-037 Full: out_ready=0, both valid -> exactly 4 accepted, then in_ready=0; one pop -> exactly one new grant.
REQ-038 Reset mid-stream: rst_n low for 1 cycle with 3 entries queued -> out_valid=0, count=0, next grant to lane 0.
REQ-039 Stats: with XI_MERGE_STATS_EN, 5 lane-0 and 3 lane-1 accepts -> grant_cnt={3,5}; without the macro -> grant_cnt=0.
REQ-040 Backpressure hold: out_ready toggles randomly -> out_data is stable while stalled; sequence equals accept order with no loss or duplication.
